tick_scheduler: RTL and testbench

- Programmable multi-channel clock-enable generator and controller.
- Shares one clock domain between NUM_CH independent rate channels, for example display refresh, debounce sampling and game tick.
- Each channel produces a single-cycle tick and a 50%-style toggle, replacing free-running derived clocks.
- Divisors and enables are loaded at runtime through a valid/ready config port. A small FSM sequences run/idle and config application.

---
 rtl/tick_sched_pkg.sv | 20 ++
 rtl/tick_scheduler_channel.sv | 56 +++++
 rtl/tick_scheduler.sv | 95 +++++++++
 tb/tb_tick_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared state encoding and helper functions for the tick scheduler.
package tick_sched_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_APPLY = 2'd2;

   // Widest counter the divisor helper handles.
   localparam int MAX_CNT_W = 64;

   function automatic int ch_width(input int num_ch);
      return (num_ch <= 2) ? 1 : $clog2(num_ch);
   endfunction

   // A zero divisor would never reach terminal count, so it runs as divide-by-one.
   function automatic logic [MAX_CNT_W-1:0] eff_div(input logic [MAX_CNT_W-1:0] div);
      return (div == '0) ? MAX_CNT_W'(1) : div;
   endfunction

endpackage

// File: rtl/tick_scheduler_channel.sv
// One rate channel: holds its divisor/enable and produces a registered tick and toggle.
module tick_channel
   import tick_sched_pkg::*;
#(
   parameter int          CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 50000000
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             count_en,
   input  logic             load,
   input  logic [CNT_W-1:0] div,
   input  logic             en,
   output logic             tick,
   output logic             toggle
);

   logic [CNT_W-1:0]     div_q;
   logic [CNT_W-1:0]     cnt;
   logic                 en_q;
   logic [MAX_CNT_W-1:0] d_ext;
   logic                 terminal;

   assign d_ext    = eff_div(MAX_CNT_W'(div_q));
   assign terminal = (MAX_CNT_W'(cnt) == (d_ext - MAX_CNT_W'(1)));

   // A load outranks a coincident terminal count, so no tick escapes a reconfigure.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         div_q  <= CNT_W'(DEFAULT_DIV);
         en_q   <= 1'b1;
         cnt    <= '0;
         tick   <= 1'b0;
         toggle <= 1'b0;
      end else if (load) begin
         div_q  <= div;
         en_q   <= en;
         cnt    <= '0;
         tick   <= 1'b0;
         toggle <= 1'b0;
      end else if (count_en && en_q) begin
         if (terminal) begin
            cnt    <= '0;
            tick   <= 1'b1;
            toggle <= ~toggle;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
         end
      end else begin
         cnt  <= '0;
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable generator: run/idle FSM, config latch and channel decode.
//
// state | meaning
// IDLE  | counters held at 0, config port open
// RUN   | enabled channels count, config port open
// APPLY | one cycle: latched config written to its channel, port closed
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter  int          NUM_CH      = 4,
   parameter  int          CNT_W       = 32,
   parameter  int unsigned DEFAULT_DIV = 50000000,
   localparam int          CH_W        = ch_width(NUM_CH)
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              run_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic [CNT_W-1:0]  cfg_div_i,
   input  logic              cfg_en_i,
   output logic [NUM_CH-1:0] tick_o,
   output logic [NUM_CH-1:0] toggle_o,
   output logic              busy_o
);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic              accept;
   logic              count_en;
   logic [CH_W-1:0]   ch_q;
   logic [CNT_W-1:0]  div_q;
   logic              en_q;
   logic [NUM_CH-1:0] load;

   // Ready drops while reset is asserted so nothing is accepted on a reset edge.
   assign cfg_ready_o = rst_i && (state != ST_APPLY);
   assign busy_o      = (state == ST_APPLY);
   assign accept      = cfg_valid_i && cfg_ready_o;
   assign count_en    = run_i && (state != ST_IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept)     state_nxt = ST_APPLY;
            else if (run_i) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (accept)      state_nxt = ST_APPLY;
            else if (!run_i) state_nxt = ST_IDLE;
         end
         ST_APPLY: state_nxt = run_i ? ST_RUN : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ch_q  <= '0;
         div_q <= '0;
         en_q  <= 1'b0;
      end else if (accept) begin
         ch_q  <= cfg_ch_i;
         div_q <= cfg_div_i;
         en_q  <= cfg_en_i;
      end
   end

   // Channel indices beyond NUM_CH match no slot, so such a config is a no-op.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load[i] = busy_o && (ch_q == CH_W'(i));

      tick_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_i    (rst_i),
         .count_en (count_en),
         .load     (load[i]),
         .div      (div_q),
         .en       (en_q),
         .tick     (tick_o[i]),
         .toggle   (toggle_o[i])
      );
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: directed scenarios then random traffic vs a cycle-count model.
module tb_tick_scheduler;

   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 8;
   localparam int DEF_DIV = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             run;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [1:0]       cfg_ch;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_en;
   logic [3:0]       tick;
   logic [3:0]       toggle;
   logic             busy;

   always #5 clk = ~clk;

   tick_scheduler #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEF_DIV)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .run_i       (run),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_ch_i    (cfg_ch),
      .cfg_div_i   (cfg_div),
      .cfg_en_i    (cfg_en),
      .tick_o      (tick),
      .toggle_o    (toggle),
      .busy_o      (busy)
   );

   typedef struct packed {
      logic [3:0] tick;
      logic [3:0] toggle;
      logic       ready;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: each channel tracks counted cycles since its last tick or clear.
   typedef enum {M_IDLE, M_RUN, M_APPLY} mode_t;
   mode_t    mode = M_IDLE;
   int       m_div[NUM_CH];
   bit       m_en[NUM_CH];
   int       m_elapsed[NUM_CH];
   bit [3:0] m_tog;
   int       p_ch;
   int       p_div;
   bit       p_en;

   function automatic int period(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   task automatic model_edge(output exp_t e);
      bit    accept;
      bit    counting;
      mode_t nxt;
      e = '0;
      if (!rst) begin
         mode  = M_IDLE;
         m_tog = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]     = DEF_DIV;
            m_en[i]      = 1'b1;
            m_elapsed[i] = 0;
         end
         return;
      end
      accept   = cfg_valid && (mode != M_APPLY);
      counting = run && (mode != M_IDLE);
      for (int i = 0; i < NUM_CH; i++) begin
         if (mode == M_APPLY && p_ch == i) begin
            m_div[i]     = p_div;
            m_en[i]      = p_en;
            m_elapsed[i] = 0;
            m_tog[i]     = 1'b0;
         end else if (counting && m_en[i]) begin
            m_elapsed[i]++;
            if (m_elapsed[i] == period(m_div[i])) begin
               e.tick[i]    = 1'b1;
               m_tog[i]     = ~m_tog[i];
               m_elapsed[i] = 0;
            end
         end else begin
            m_elapsed[i] = 0;
         end
      end
      if (mode == M_APPLY) begin
         nxt = run ? M_RUN : M_IDLE;
      end else if (accept) begin
         nxt   = M_APPLY;
         p_ch  = int'(cfg_ch);
         p_div = int'(cfg_div);
         p_en  = cfg_en;
      end else begin
         nxt = run ? M_RUN : M_IDLE;
      end
      mode     = nxt;
      e.toggle = m_tog;
      e.ready  = (mode != M_APPLY);
      e.busy   = (mode == M_APPLY);
   endtask

   task automatic step();
      exp_t e;
      model_edge(e);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic send_cfg(input int ch, input int div, input bit en);
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_div   = CNT_W'(div);
      cfg_en    = en;
      step();
      cfg_valid = 1'b0;
   endtask

   always @(posedge clk) begin
      exp_t e;
      exp_t got;
      #1;
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         got = '{tick: tick, toggle: toggle, ready: cfg_ready, busy: busy};
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL cycle_outputs t=%0t got tick=%h toggle=%h ready=%b busy=%b expected tick=%h toggle=%h ready=%b busy=%b",
                     $time, got.tick, got.toggle, got.ready, got.busy,
                     e.tick, e.toggle, e.ready, e.busy);
         end
      end
   end

   initial begin
      int r;
      int waited;
      rst       = 1'b0;
      run       = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
      cfg_en    = 1'b1;
      steps(3);

      n_cmp++;
      if (tick !== 4'h0 || toggle !== 4'h0 || cfg_ready !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state t=%0t tick=%h toggle=%h ready=%b busy=%b expected all zero",
                  $time, tick, toggle, cfg_ready, busy);
      end

      // Default cadence after reset release
      rst = 1'b1;
      run = 1'b1;
      steps(20);

      // ch2 to divide-by-one while running
      send_cfg(2, 1, 1'b1);
      steps(12);

      // zero divisor on ch1, then disable ch0
      send_cfg(1, 0, 1'b1);
      step();
      send_cfg(0, 5, 1'b0);
      steps(12);

      // Accept timed so APPLY lands on ch3's terminal count
      for (waited = 0; waited < 20 && (m_elapsed[3] != period(m_div[3]) - 2); waited++) step();
      n_cmp++;
      if (m_elapsed[3] != period(m_div[3]) - 2) begin
         n_bad++;
         $display("FAIL wait_expired t=%0t ch3 phase %0d never reached %0d within %0d cycles",
                  $time, m_elapsed[3], period(m_div[3]) - 2, waited);
      end
      send_cfg(3, 3, 1'b1);
      steps(10);

      // Stop mid-count, configure while idle, restart
      steps(2);
      run = 1'b0;
      steps(3);
      send_cfg(2, 2, 1'b1);
      steps(3);
      run = 1'b1;
      steps(12);

      // Reset landing on the APPLY cycle drops the pending config
      send_cfg(1, 7, 1'b1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      steps(14);

      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 19) == 0) run = ~run;
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch    = 2'($urandom_range(0, NUM_CH - 1));
         r         = int'($urandom_range(0, 9));
         cfg_div   = (r < 8) ? CNT_W'(r) : CNT_W'($urandom_range(0, 20));
         cfg_en    = ($urandom_range(0, 4) != 0);
         step();
      end
      cfg_valid = 1'b0;
      steps(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
